// File: rtl/mips_exec_core.sv
// Decode, ALU, branch/jump resolution and 32x32 register file of the multi-cycle MIPS bus CPU.
// Everything except the register-file write is combinational from instr/pc/mem_rdata.
package mips_exec_pkg;

    typedef enum logic [2:0] {
        ALU_AND  = 3'b000,
        ALU_OR   = 3'b001,
        ALU_ADD  = 3'b010,
        ALU_XOR  = 3'b011,
        ALU_SLTU = 3'b100,
        ALU_SUB  = 3'b110,
        ALU_SLT  = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        WB_ALU  = 2'd0,
        WB_MEM  = 2'd1,
        WB_LINK = 2'd2
    } wb_sel_e;

    typedef enum logic [1:0] {
        B_RT   = 2'd0,
        B_SEXT = 2'd1,
        B_ZEXT = 2'd2,
        B_LUI  = 2'd3
    } b_sel_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_JALR  = 6'h09;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_XOR   = 6'h26;
    localparam logic [5:0] FN_SLT   = 6'h2A;
    localparam logic [5:0] FN_SLTU  = 6'h2B;

    typedef struct packed {
        alu_op_e alu_op;
        b_sel_e  b_sel;
        logic    a_zero;
        logic    wb_en;
        wb_sel_e wb_sel;
        logic    dest_rd;
        logic    dest_ra;
        logic    mem_read;
        logic    mem_write;
        logic    is_beq;
        logic    is_bne;
        logic    is_jump;
        logic    is_jreg;
        logic    illegal;
    } ctrl_t;

endpackage

module mips_exec_core
    import mips_exec_pkg::*;
#(
    parameter logic [31:0] RESET_VAL = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic [31:0] pc,
    input  logic [31:0] mem_rdata,
    input  logic        commit,
    output logic [31:0] alu_out,
    output logic        zero,
    output logic [31:0] rs_data,
    output logic [31:0] rt_data,
    output logic        mem_read,
    output logic        mem_write,
    output logic        take_branch,
    output logic [31:0] target,
    output logic        illegal,
    output logic [31:0] register_v0
);

    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [5:0]  funct;
    logic [15:0] imm;

    assign op    = instr[31:26];
    assign rs    = instr[25:21];
    assign rt    = instr[20:16];
    assign rd    = instr[15:11];
    assign funct = instr[5:0];
    assign imm   = instr[15:0];

    // Shift amount field is never used by the supported instruction set.
    logic unused_shamt;
    assign unused_shamt = ^instr[10:6];

    ctrl_t ctrl;

    // NOTE: every field gets a default before the case so no path leaves a latch.
    always_comb begin
        ctrl        = '0;
        ctrl.alu_op = ALU_ADD;
        ctrl.b_sel  = B_RT;
        ctrl.wb_sel = WB_ALU;
        unique case (op)
            OP_RTYPE: begin
                ctrl.dest_rd = 1'b1;
                ctrl.wb_en   = 1'b1;
                unique case (funct)
                    FN_ADDU: ctrl.alu_op = ALU_ADD;
                    FN_SUBU: ctrl.alu_op = ALU_SUB;
                    FN_AND:  ctrl.alu_op = ALU_AND;
                    FN_OR:   ctrl.alu_op = ALU_OR;
                    FN_XOR:  ctrl.alu_op = ALU_XOR;
                    FN_SLT:  ctrl.alu_op = ALU_SLT;
                    FN_SLTU: ctrl.alu_op = ALU_SLTU;
                    FN_JR: begin
                        ctrl.wb_en   = 1'b0;
                        ctrl.is_jreg = 1'b1;
                    end
                    FN_JALR: begin
                        ctrl.wb_sel  = WB_LINK;
                        ctrl.is_jreg = 1'b1;
                    end
                    default: begin
                        ctrl.wb_en   = 1'b0;
                        ctrl.illegal = 1'b1;
                    end
                endcase
            end
            OP_ADDIU: begin
                ctrl.b_sel = B_SEXT;
                ctrl.wb_en = 1'b1;
            end
            OP_SLTI: begin
                ctrl.alu_op = ALU_SLT;
                ctrl.b_sel  = B_SEXT;
                ctrl.wb_en  = 1'b1;
            end
            OP_SLTIU: begin
                ctrl.alu_op = ALU_SLTU;
                ctrl.b_sel  = B_SEXT;
                ctrl.wb_en  = 1'b1;
            end
            OP_ANDI: begin
                ctrl.alu_op = ALU_AND;
                ctrl.b_sel  = B_ZEXT;
                ctrl.wb_en  = 1'b1;
            end
            OP_ORI: begin
                ctrl.alu_op = ALU_OR;
                ctrl.b_sel  = B_ZEXT;
                ctrl.wb_en  = 1'b1;
            end
            OP_XORI: begin
                ctrl.alu_op = ALU_XOR;
                ctrl.b_sel  = B_ZEXT;
                ctrl.wb_en  = 1'b1;
            end
            // LUI is routed through the ALU as 0 | {imm, 16'h0} so alu_out shows the result.
            OP_LUI: begin
                ctrl.alu_op = ALU_OR;
                ctrl.b_sel  = B_LUI;
                ctrl.a_zero = 1'b1;
                ctrl.wb_en  = 1'b1;
            end
            OP_LW: begin
                ctrl.b_sel    = B_SEXT;
                ctrl.wb_en    = 1'b1;
                ctrl.wb_sel   = WB_MEM;
                ctrl.mem_read = 1'b1;
            end
            OP_SW: begin
                ctrl.b_sel     = B_SEXT;
                ctrl.mem_write = 1'b1;
            end
            OP_BEQ: begin
                ctrl.alu_op = ALU_SUB;
                ctrl.is_beq = 1'b1;
            end
            OP_BNE: begin
                ctrl.alu_op = ALU_SUB;
                ctrl.is_bne = 1'b1;
            end
            OP_J: ctrl.is_jump = 1'b1;
            OP_JAL: begin
                ctrl.is_jump = 1'b1;
                ctrl.wb_en   = 1'b1;
                ctrl.wb_sel  = WB_LINK;
                ctrl.dest_ra = 1'b1;
            end
            default: ctrl.illegal = 1'b1;
        endcase
    end

    logic [31:0] imm_sext;
    logic [31:0] alu_a;
    logic [31:0] alu_b;

    assign imm_sext = {{16{imm[15]}}, imm};
    assign alu_a    = ctrl.a_zero ? 32'h0 : rs_data;

    always_comb begin
        alu_b = rt_data;
        unique case (ctrl.b_sel)
            B_RT:    alu_b = rt_data;
            B_SEXT:  alu_b = imm_sext;
            B_ZEXT:  alu_b = {16'h0, imm};
            B_LUI:   alu_b = {imm, 16'h0};
            default: alu_b = rt_data;
        endcase
    end

    always_comb begin
        alu_out = 32'h0;
        case (ctrl.alu_op)
            ALU_AND:  alu_out = alu_a & alu_b;
            ALU_OR:   alu_out = alu_a | alu_b;
            ALU_ADD:  alu_out = alu_a + alu_b;
            ALU_XOR:  alu_out = alu_a ^ alu_b;
            ALU_SUB:  alu_out = alu_a - alu_b;
            ALU_SLT:  alu_out = {31'h0, $signed(alu_a) < $signed(alu_b)};
            ALU_SLTU: alu_out = {31'h0, alu_a < alu_b};
            default:  alu_out = 32'h0;
        endcase
    end

    assign zero      = (alu_out == 32'h0);
    assign mem_read  = ctrl.mem_read;
    assign mem_write = ctrl.mem_write;
    assign illegal   = ctrl.illegal;

    logic [31:0] pc_plus4;
    logic [31:0] pc_plus8;
    logic [31:0] branch_target;
    logic [31:0] jump_target;

    assign pc_plus4      = pc + 32'd4;
    assign pc_plus8      = pc + 32'd8;
    assign branch_target = pc_plus4 + {imm_sext[29:0], 2'b00};
    assign jump_target   = {pc_plus4[31:28], instr[25:0], 2'b00};

    assign take_branch = (ctrl.is_beq & zero) | (ctrl.is_bne & ~zero) |
                         ctrl.is_jump | ctrl.is_jreg;

    always_comb begin
        target = 32'h0;
        if (take_branch) begin
            if (ctrl.is_jump)      target = jump_target;
            else if (ctrl.is_jreg) target = rs_data;
            else                   target = branch_target;
        end
    end

    logic [4:0]  dest;
    logic [31:0] wb_data;
    logic        reg_we;

    assign dest = ctrl.dest_ra ? 5'd31 : (ctrl.dest_rd ? rd : rt);

    always_comb begin
        wb_data = alu_out;
        unique case (ctrl.wb_sel)
            WB_ALU:  wb_data = alu_out;
            WB_MEM:  wb_data = mem_rdata;
            WB_LINK: wb_data = pc_plus8;
            default: wb_data = alu_out;
        endcase
    end

    assign reg_we = commit & ctrl.wb_en & (dest != 5'd0) & ~ctrl.illegal;

    logic [31:0] regs [32];

    // NOTE: the register file is plain flops, so it can and must take the async clear;
    // state is updated with non-blocking assignments only.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= (i == 0) ? 32'h0 : RESET_VAL;
            end
        end else if (reg_we) begin
            regs[dest] <= wb_data;
        end
    end

    assign rs_data     = (rs == 5'd0) ? 32'h0 : regs[rs];
    assign rt_data     = (rt == 5'd0) ? 32'h0 : regs[rt];
    assign register_v0 = regs[2];

endmodule

// File: tb/tb_mips_exec_core.sv
// Directed bench for mips_exec_core: expectations are queued as each step is driven and
// compared against the DUT outputs once they have settled.
module tb_mips_exec_core;

    logic        clk;
    logic        reset;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] mem_rdata;
    logic        commit;
    logic [31:0] alu_out;
    logic        zero;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        mem_read;
    logic        mem_write;
    logic        take_branch;
    logic [31:0] target;
    logic        illegal;
    logic [31:0] register_v0;

    mips_exec_core dut (
        .clk         (clk),
        .reset       (reset),
        .instr       (instr),
        .pc          (pc),
        .mem_rdata   (mem_rdata),
        .commit      (commit),
        .alu_out     (alu_out),
        .zero        (zero),
        .rs_data     (rs_data),
        .rt_data     (rt_data),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .take_branch (take_branch),
        .target      (target),
        .illegal     (illegal),
        .register_v0 (register_v0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef enum {S_ALU, S_ZERO, S_RS, S_RT, S_MR, S_MW, S_TB, S_TGT, S_ILL, S_V0} sig_e;

    typedef struct {
        string       tag;
        sig_e        sig;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    function automatic logic [31:0] enc_r(logic [4:0] rs, logic [4:0] rt, logic [4:0] rd,
                                          logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'h00, fn};
    endfunction

    function automatic logic [31:0] enc_i(logic [5:0] op, logic [4:0] rs, logic [4:0] rt,
                                          logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_j(logic [5:0] op, logic [25:0] idx);
        return {op, idx};
    endfunction

    function automatic logic [31:0] observe(sig_e s);
        case (s)
            S_ALU:   return alu_out;
            S_ZERO:  return {31'h0, zero};
            S_RS:    return rs_data;
            S_RT:    return rt_data;
            S_MR:    return {31'h0, mem_read};
            S_MW:    return {31'h0, mem_write};
            S_TB:    return {31'h0, take_branch};
            S_TGT:   return target;
            S_ILL:   return {31'h0, illegal};
            default: return register_v0;
        endcase
    endfunction

    task automatic expect_sig(string tag, sig_e s, logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.sig = s;
        e.exp = v;
        sb.push_back(e);
    endtask

    task automatic flush();
        exp_t        e;
        logic [31:0] obs;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = observe(e.sig);
            total++;
            assert (obs === e.exp) else begin
                bad++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic drive(logic [31:0] i, logic [31:0] p, logic [31:0] rdata, logic c);
        @(negedge clk);
        instr     = i;
        pc        = p;
        mem_rdata = rdata;
        commit    = c;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        commit = 1'b0;
    endtask

    // Drive with commit, compare settled combinational outputs, then let the write happen.
    task automatic exec(logic [31:0] i, logic [31:0] p, logic [31:0] rdata);
        drive(i, p, rdata, 1'b1);
        flush();
        tick();
    endtask

    task automatic read_reg(string tag, logic [4:0] r, logic [31:0] v);
        expect_sig(tag, S_RS, v);
        drive(enc_r(r, 5'd0, 5'd0, 6'h21), 32'h0, 32'h0, 1'b0);
        flush();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        reset     = 1'b0;
        commit    = 1'b0;
        instr     = 32'h0;
        pc        = 32'h0;
        mem_rdata = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        expect_sig("reset_v0", S_V0, 32'h0);
        flush();
        @(negedge clk);
        reset = 1'b1;

        // ADDIU $2,$0,0x7FFF; before the edge $v0 still shows the old value
        expect_sig("addiu_alu", S_ALU, 32'h0000_7FFF);
        expect_sig("addiu_pre_v0", S_V0, 32'h0);
        expect_sig("addiu_ill", S_ILL, 32'h0);
        exec(enc_i(6'h09, 5'd0, 5'd2, 16'h7FFF), 32'h0, 32'h0);
        expect_sig("addiu_v0", S_V0, 32'h0000_7FFF);
        flush();
        read_reg("r0_read", 5'd0, 32'h0);

        expect_sig("addiu_neg", S_ALU, 32'hFFFF_FFFF);
        exec(enc_i(6'h09, 5'd0, 5'd3, 16'hFFFF), 32'h0, 32'h0);
        expect_sig("slt_alu", S_ALU, 32'h1);
        exec(enc_r(5'd3, 5'd0, 5'd4, 6'h2A), 32'h0, 32'h0);
        read_reg("slt_r4", 5'd4, 32'h1);
        expect_sig("sltu_alu", S_ALU, 32'h0);
        expect_sig("sltu_zero", S_ZERO, 32'h1);
        exec(enc_r(5'd3, 5'd0, 5'd4, 6'h2B), 32'h0, 32'h0);
        read_reg("sltu_r4", 5'd4, 32'h0);
        expect_sig("lui_alu", S_ALU, 32'h8000_0000);
        exec(enc_i(6'h0F, 5'd0, 5'd5, 16'h8000), 32'h0, 32'h0);
        read_reg("lui_r5", 5'd5, 32'h8000_0000);

        expect_sig("andi_zext", S_ALU, 32'h0000_8001);
        exec(enc_i(6'h0C, 5'd3, 5'd6, 16'h8001), 32'h0, 32'h0);
        expect_sig("xor_alu", S_ALU, 32'hFFFF_7FFE);
        exec(enc_r(5'd6, 5'd3, 5'd7, 6'h26), 32'h0, 32'h0);
        expect_sig("subu_alu", S_ALU, 32'hFFFF_7FFF);
        exec(enc_r(5'd0, 5'd6, 5'd7, 6'h23), 32'h0, 32'h0);
        read_reg("subu_r7", 5'd7, 32'hFFFF_7FFF);
        expect_sig("or_alu", S_ALU, 32'h8000_8001);
        exec(enc_r(5'd6, 5'd5, 5'd11, 6'h25), 32'h0, 32'h0);
        expect_sig("and_alu", S_ALU, 32'h0000_8001);
        exec(enc_r(5'd3, 5'd6, 5'd11, 6'h24), 32'h0, 32'h0);
        expect_sig("sltiu_sext", S_ALU, 32'h1);
        exec(enc_i(6'h0B, 5'd6, 5'd9, 16'h8000), 32'h0, 32'h0);
        expect_sig("slti_alu", S_ALU, 32'h1);
        exec(enc_i(6'h0A, 5'd3, 5'd9, 16'h0001), 32'h0, 32'h0);
        expect_sig("ori_alu", S_ALU, 32'h0000_F0F0);
        exec(enc_i(6'h0D, 5'd0, 5'd10, 16'hF0F0), 32'h0, 32'h0);
        expect_sig("xori_alu", S_ALU, 32'h0);
        expect_sig("xori_zero", S_ZERO, 32'h1);
        exec(enc_i(6'h0E, 5'd6, 5'd10, 16'h8001), 32'h0, 32'h0);

        // Memory access: LW $2,4($1) then SW $3,8($1)
        exec(enc_i(6'h09, 5'd0, 5'd1, 16'h0100), 32'h0, 32'h0);
        expect_sig("lw_addr", S_ALU, 32'h0000_0104);
        expect_sig("lw_mem_read", S_MR, 32'h1);
        expect_sig("lw_mem_write", S_MW, 32'h0);
        exec(enc_i(6'h23, 5'd1, 5'd2, 16'h0004), 32'h0, 32'hDEAD_BEEF);
        expect_sig("lw_v0", S_V0, 32'hDEAD_BEEF);
        flush();
        expect_sig("sw_addr", S_ALU, 32'h0000_0108);
        expect_sig("sw_mem_write", S_MW, 32'h1);
        expect_sig("sw_mem_read", S_MR, 32'h0);
        expect_sig("sw_data", S_RT, 32'hFFFF_FFFF);
        exec(enc_i(6'h2B, 5'd1, 5'd3, 16'h0008), 32'h0, 32'h1234_5678);
        read_reg("sw_no_write", 5'd3, 32'hFFFF_FFFF);

        // Branches at pc = 0x1000
        expect_sig("beq_take", S_TB, 32'h1);
        expect_sig("beq_target", S_TGT, 32'h0000_0FFC);
        drive(enc_i(6'h04, 5'd1, 5'd1, 16'hFFFE), 32'h0000_1000, 32'h0, 1'b0);
        flush();
        expect_sig("bne_not_take", S_TB, 32'h0);
        expect_sig("bne_target0", S_TGT, 32'h0);
        drive(enc_i(6'h05, 5'd1, 5'd1, 16'hFFFE), 32'h0000_1000, 32'h0, 1'b0);
        flush();
        expect_sig("bne_take", S_TB, 32'h1);
        expect_sig("bne_target", S_TGT, 32'h0000_0FFC);
        drive(enc_i(6'h05, 5'd1, 5'd0, 16'hFFFE), 32'h0000_1000, 32'h0, 1'b0);
        flush();

        // Jumps
        expect_sig("j_target", S_TGT, 32'h0FFF_FFFC);
        drive(enc_j(6'h02, 26'h3FF_FFFF), 32'h0000_0000, 32'h0, 1'b0);
        flush();
        expect_sig("jal_take", S_TB, 32'h1);
        expect_sig("jal_target", S_TGT, 32'hB040_0000);
        exec(enc_j(6'h03, 26'h010_0000), 32'hBFC0_0000, 32'h0);
        read_reg("jal_r31", 5'd31, 32'hBFC0_0008);
        expect_sig("jr_take", S_TB, 32'h1);
        expect_sig("jr_target", S_TGT, 32'hBFC0_0008);
        drive(enc_r(5'd31, 5'd0, 5'd0, 6'h08), 32'h0000_3000, 32'h0, 1'b0);
        flush();
        expect_sig("jalr_target", S_TGT, 32'hBFC0_0008);
        exec(enc_r(5'd31, 5'd0, 5'd8, 6'h09), 32'h0000_2000, 32'h0);
        read_reg("jalr_r8", 5'd8, 32'h0000_2008);

        // Illegal encodings never write back
        expect_sig("ill_op", S_ILL, 32'h1);
        expect_sig("ill_op_tb", S_TB, 32'h0);
        exec(enc_i(6'h3F, 5'd0, 5'd2, 16'h0001), 32'h0, 32'h0);
        expect_sig("ill_funct", S_ILL, 32'h1);
        exec(enc_r(5'd1, 5'd1, 5'd2, 6'h00), 32'h0, 32'h0);
        expect_sig("ill_v0_kept", S_V0, 32'hDEAD_BEEF);
        flush();

        // $0 is never written
        expect_sig("r0_write_alu", S_ALU, 32'h5);
        exec(enc_i(6'h09, 5'd0, 5'd0, 16'h0005), 32'h0, 32'h0);
        read_reg("r0_after_write", 5'd0, 32'h0);

        // Reset asserted with a commit pending on the next edge
        drive(enc_i(6'h09, 5'd0, 5'd2, 16'h0055), 32'h0, 32'h0, 1'b1);
        reset = 1'b0;
        #1;
        expect_sig("rst_v0_async", S_V0, 32'h0);
        expect_sig("rst_comb_alu", S_ALU, 32'h0000_0055);
        flush();
        tick();
        expect_sig("rst_commit_blocked", S_V0, 32'h0);
        flush();
        read_reg("rst_r31", 5'd31, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        read_reg("post_rst_r1", 5'd1, 32'h0);
        expect_sig("post_rst_v0", S_V0, 32'h0);
        flush();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
